// File: rtl/sid.sv
// Package sid: SID register-bus types shared by the bus master and the register block.
// Holds the command format, the bus record driven towards the SID cores and small helpers.
package sid;

  typedef logic [7:0] reg8_t;

  // Bus record seen by the SID register block (MOS6510-style bus cycle).
  typedef struct packed {
    logic       phi2;
    logic       r_w_n;
    logic [4:0] addr;
    reg8_t      data;
    logic       res;
  } bus_i_t;

  typedef enum logic [1:0] {
    OP_WAIT  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RESET = 2'd3
  } bus_op_t;

  typedef struct packed {
    bus_op_t    op;
    logic       chip;
    logic [4:0] addr;
    reg8_t      data;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESET  = 2'd3
  } bm_state_t;

  localparam int WAIT_CNT_W = 13;

  // One-hot chip select for SID 0 / SID 1.
  function automatic logic [1:0] chip_sel(input logic chip);
    return chip ? 2'b10 : 2'b01;
  endfunction

  // Number of idle bus cycles a WAIT command occupies; zero still costs one cycle.
  function automatic logic [WAIT_CNT_W-1:0] wait_len(input logic [4:0] addr, input reg8_t data);
    logic [WAIT_CNT_W-1:0] len;
    len = {addr, data};
    return (len == 13'd0) ? 13'd1 : len;
  endfunction

endpackage

// File: rtl/sid_phi2_gen.sv
// sid_phi2_gen: phi2 phase counter. phase runs 0..PHI2_DIV-1, phi2 is low for the first
// half and high for the second half; boundary marks the last clk of every phi2 cycle.
module sid_phi2_gen #(
  parameter int PHI2_DIV = 24,
  parameter int PHASE_W  = $clog2(PHI2_DIV)
) (
  input  logic               clk,
  input  logic               res,
  output logic               phi2,
  output logic [PHASE_W-1:0] phase,
  output logic               boundary
);

  localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(PHI2_DIV - 1);
  localparam logic [PHASE_W-1:0] HALF_M1 = PHASE_W'(PHI2_DIV / 2 - 1);

  generate
    if (((PHI2_DIV % 2) != 0) || (PHI2_DIV < 4)) begin : g_bad_div
      $error("sid_phi2_gen: PHI2_DIV must be even and >= 4");
    end
  endgenerate

  // Phase counter with phi2 registered alongside it so both change on the same edge.
  always_ff @(posedge clk) begin
    if (res) begin
      phase <= '0;
      phi2  <= 1'b0;
    end else if (phase == LAST) begin
      phase <= '0;
      phi2  <= 1'b0;
    end else begin
      phase <= phase + PHASE_W'(1);
      phi2  <= (phase >= HALF_M1);
    end
  end

  assign boundary = (phase == LAST);

endmodule

// File: rtl/sid_bus_master.sv
// sid_bus_master: turns register commands into whole-phi2-cycle SID bus cycles for two chips.
// Configuration macro: SID_BUS_MASTER_READ_EN enables READ bus cycles with rd_valid/rd_data;
// without it a READ costs one idle bus cycle and rd_valid/rd_data are tied low.
module sid_bus_master
  import sid::*;
#(
  parameter int PHI2_DIV   = 24,
  parameter int RES_CYCLES = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  bus_cmd_t   cmd,
  output bus_i_t     bus_o,
  output logic [1:0] cs_o,
  input  reg8_t      data_i,
  output logic       rd_valid,
  output reg8_t      rd_data,
  output logic       busy
);

  localparam int PHASE_W   = $clog2(PHI2_DIV);
  localparam int RES_CNT_W = $clog2(RES_CYCLES + 1);
  localparam logic [PHASE_W-1:0]   PRE_LAST = PHASE_W'(PHI2_DIV - 2);
  localparam logic [RES_CNT_W-1:0] RES_LOAD = RES_CNT_W'(RES_CYCLES);

  logic                  phi2_s;
  logic [PHASE_W-1:0]    phase_s;
  logic                  boundary_s;
  logic                  pre_boundary_s;
  logic                  ends_s;
  logic                  take_s;

  bm_state_t             state_r;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic [RES_CNT_W-1:0]  res_cnt_r;
  logic                  cmd_ready_r;
  logic                  r_w_n_r;
  logic [4:0]            addr_r;
  reg8_t                 data_r;
  logic                  bus_res_r;
  logic [1:0]            cs_r;

  sid_phi2_gen #(
    .PHI2_DIV (PHI2_DIV),
    .PHASE_W  (PHASE_W)
  ) u_phi2_gen (
    .clk      (clk),
    .res      (res),
    .phi2     (phi2_s),
    .phase    (phase_s),
    .boundary (boundary_s)
  );

  assign pre_boundary_s = (phase_s == PRE_LAST);
  assign take_s         = boundary_s & cmd_valid & cmd_ready_r;

  // Does the bus cycle now in progress finish the current command (or is there none)?
  always_comb begin
    ends_s = 1'b1;
    case (state_r)
      ST_IDLE:   ends_s = 1'b1;
      ST_ACCESS: ends_s = 1'b1;
      ST_WAIT:   ends_s = (wait_cnt_r == 13'd1);
      ST_RESET:  ends_s = (res_cnt_r == RES_CNT_W'(1));
      default:   ends_s = 1'b1;
    endcase
  end

`ifdef SID_BUS_MASTER_READ_EN
  logic  rd_pend_r;
  logic  rd_valid_r;
  reg8_t rd_data_r;
`endif

  // Command FSM: accepts at phi2 boundaries and registers every bus field except phi2.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= '0;
      res_cnt_r   <= '0;
      cmd_ready_r <= 1'b0;
      r_w_n_r     <= 1'b1;
      addr_r      <= 5'd0;
      data_r      <= 8'd0;
      bus_res_r   <= 1'b0;
      cs_r        <= 2'b00;
`ifdef SID_BUS_MASTER_READ_EN
      rd_pend_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= 8'd0;
`endif
    end else begin
      // Ready is raised for exactly the boundary clk of a finishing bus cycle.
      cmd_ready_r <= pre_boundary_s & ends_s;
`ifdef SID_BUS_MASTER_READ_EN
      rd_valid_r <= 1'b0;
      if (boundary_s && (state_r == ST_ACCESS) && rd_pend_r) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= data_i;
      end
`endif
      if (boundary_s) begin
        if (take_s || ends_s) begin
          // Next bus cycle starts idle unless the new command overrides it below.
          state_r   <= ST_IDLE;
          r_w_n_r   <= 1'b1;
          addr_r    <= 5'd0;
          data_r    <= 8'd0;
          bus_res_r <= 1'b0;
          cs_r      <= 2'b00;
`ifdef SID_BUS_MASTER_READ_EN
          rd_pend_r <= 1'b0;
`endif
        end
        if (take_s) begin
          case (cmd.op)
            OP_WRITE: begin
              state_r <= ST_ACCESS;
              r_w_n_r <= 1'b0;
              addr_r  <= cmd.addr;
              data_r  <= cmd.data;
              cs_r    <= chip_sel(cmd.chip);
            end
            OP_READ: begin
`ifdef SID_BUS_MASTER_READ_EN
              state_r   <= ST_ACCESS;
              addr_r    <= cmd.addr;
              cs_r      <= chip_sel(cmd.chip);
              rd_pend_r <= 1'b1;
`else
              state_r    <= ST_WAIT;
              wait_cnt_r <= 13'd1;
`endif
            end
            OP_RESET: begin
              state_r   <= ST_RESET;
              res_cnt_r <= RES_LOAD;
              bus_res_r <= 1'b1;
            end
            OP_WAIT: begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= wait_len(cmd.addr, cmd.data);
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end else if (!ends_s) begin
          case (state_r)
            ST_WAIT:  wait_cnt_r <= wait_cnt_r - 13'd1;
            ST_RESET: res_cnt_r  <= res_cnt_r - RES_CNT_W'(1);
            default:  state_r    <= state_r;
          endcase
        end
      end
    end
  end

  assign bus_o     = '{phi2: phi2_s, r_w_n: r_w_n_r, addr: addr_r, data: data_r, res: bus_res_r};
  assign cs_o      = cs_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = (state_r != ST_IDLE);

`ifdef SID_BUS_MASTER_READ_EN
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
`else
  logic unused_data_s;
  assign unused_data_s = ^data_i;
  assign rd_valid      = 1'b0;
  assign rd_data       = 8'd0;
`endif

endmodule

// File: tb/tb_sid_bus_master.sv
// Testbench for sid_bus_master: a negedge monitor runs a bus-cycle level reference model
// (command -> list of expected bus cycles) and drives all DUT inputs; directed scenario
// tasks feed commands and add their own checks on observed event counts.
module tb_sid_bus_master;
  import sid::*;

  localparam int DIV  = 24;
  localparam int RESN = 10;

  logic       clk = 1'b0;
  logic       res;
  logic       cmd_valid;
  logic       cmd_ready;
  bus_cmd_t   cmd;
  bus_i_t     bus_o;
  logic [1:0] cs_o;
  reg8_t      data_i;
  logic       rd_valid;
  reg8_t      rd_data;
  logic       busy;

  always #5 clk = ~clk;

  sid_bus_master #(.PHI2_DIV(DIV), .RES_CYCLES(RESN)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .bus_o(bus_o), .cs_o(cs_o), .data_i(data_i), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy)
  );

  typedef struct packed {
    logic       r_w_n;
    logic [4:0] addr;
    logic [7:0] data;
    logic       res;
    logic [1:0] cs;
    logic       is_read;
    logic       busy;
  } cyc_t;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_cmd_t drv_q[$];
  cyc_t     exp_q[$];
  cyc_t     cur;
  int       ph = 0;
  logic     rd_exp = 1'b0;
  reg8_t    rd_model = 8'd0;
  reg8_t    din = 8'd0;
  int       din_fixed = -1;
  int       rst_req = 3;
  bit       chk_en = 1'b0;

  int    obs_res_hi, obs_wr, obs_wr_lo, obs_rdv, obs_rdcs, obs_idle_busy;
  reg8_t obs_rd_val;

  function automatic cyc_t idle_cyc(input logic bsy);
    cyc_t c;
    c = '0;
    c.r_w_n = 1'b1;
    c.busy = bsy;
    return c;
  endfunction

  function automatic void expand(input bus_cmd_t c);
    cyc_t e;
    int n;
    e = idle_cyc(1'b1);
    case (c.op)
      OP_WRITE: begin
        e.r_w_n = 1'b0; e.addr = c.addr; e.data = c.data; e.cs = 2'(1 << c.chip);
        exp_q.push_back(e);
      end
      OP_READ: begin
`ifdef SID_BUS_MASTER_READ_EN
        e.addr = c.addr; e.cs = 2'(1 << c.chip); e.is_read = 1'b1;
`endif
        exp_q.push_back(e);
      end
      OP_RESET: begin
        e.res = 1'b1;
        for (int i = 0; i < RESN; i++) exp_q.push_back(e);
      end
      default: begin
        n = int'({c.addr, c.data});
        if (n == 0) n = 1;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
      end
    endcase
  endfunction

  function automatic bus_cmd_t mk(input bus_op_t op, input logic chip, input logic [4:0] a,
                                  input logic [7:0] d);
    bus_cmd_t c;
    c.op = op; c.chip = chip; c.addr = a; c.data = d;
    return c;
  endfunction

  // Monitor: compare the clk in progress with the model, then drive inputs and advance the model.
  initial begin
    logic [15:0] junk;
    logic [16:0] obs_v, exp_v;
    logic        exp_rdy;
    res = 1'b1; cmd_valid = 1'b0; cmd = '0; data_i = 8'd0;
    cur = idle_cyc(1'b0);
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_cmp++;
        if (bus_o.phi2 !== (ph >= DIV / 2))
          begin n_fail++; $display("FAIL phi2 ph=%0d got=%b exp=%b", ph, bus_o.phi2, ph >= DIV / 2); end
        obs_v = {bus_o.r_w_n, bus_o.addr, bus_o.data, bus_o.res, cs_o};
        exp_v = {cur.r_w_n, cur.addr, cur.data, cur.res, cur.cs};
        n_cmp++;
        if (obs_v !== exp_v)
          begin n_fail++; $display("FAIL bus ph=%0d got=%h exp=%h (rwn,addr,data,res,cs)", ph, obs_v, exp_v); end
        exp_rdy = (ph == DIV - 1) && (exp_q.size() == 0);
        n_cmp++;
        if (cmd_ready !== exp_rdy)
          begin n_fail++; $display("FAIL cmd_ready ph=%0d got=%b exp=%b", ph, cmd_ready, exp_rdy); end
        n_cmp++;
        if ({rd_valid, rd_data} !== {rd_exp, rd_model})
          begin n_fail++; $display("FAIL rd ph=%0d got=%b/%h exp=%b/%h", ph, rd_valid, rd_data, rd_exp, rd_model); end
        n_cmp++;
        if (busy !== cur.busy)
          begin n_fail++; $display("FAIL busy ph=%0d got=%b exp=%b", ph, busy, cur.busy); end
      end
      if (bus_o.res === 1'b1) obs_res_hi++;
      if (cs_o === 2'b01 && bus_o.r_w_n === 1'b0 && bus_o.addr === 5'h18) begin
        obs_wr++;
        if (bus_o.phi2 === 1'b0) obs_wr_lo++;
      end
      if (rd_valid === 1'b1) begin obs_rdv++; obs_rd_val = rd_data; end
      if (cs_o === 2'b10 && bus_o.r_w_n === 1'b1) obs_rdcs++;
      if (busy === 1'b1 && cs_o === 2'b00 && bus_o.res === 1'b0) obs_idle_busy++;
      // inputs for the coming edge
      res = (rst_req > 0);
      if (rst_req > 0) rst_req--;
      data_i = din;
      cmd_valid = (drv_q.size() > 0);
      junk = 16'($urandom);
      cmd = cmd_valid ? drv_q[0] : bus_cmd_t'(junk);
      // model of the coming edge
      if (res) begin
        ph = 0; cur = idle_cyc(1'b0); exp_q.delete(); drv_q.delete();
        rd_exp = 1'b0; rd_model = 8'd0; chk_en = 1'b1;
      end else begin
        rd_exp = 1'b0;
        if (ph == DIV - 1) begin
          if (cmd_valid && exp_q.size() == 0) expand(drv_q.pop_front());
          if (cur.is_read) begin rd_exp = 1'b1; rd_model = din; end
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_cyc(1'b0);
          ph = 0;
          din = (din_fixed >= 0) ? 8'(din_fixed) : 8'($urandom);
        end else begin
          ph++;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0 || cur.busy) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 20000) begin n_fail++; $display("FAIL timeout %s got=%0d clk exp<20000", name, k); end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_res_edge(input string name);
    int k;
    k = 0;
    while (res !== 1'b1 && k < 50) begin @(posedge clk); k++; end
    n_cmp++;
    if (k >= 50) begin n_fail++; $display("FAIL timeout %s res got=%b exp=1", name, res); end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_res_hi = 0; obs_wr = 0; obs_wr_lo = 0; obs_rdv = 0; obs_rdcs = 0; obs_idle_busy = 0;
    obs_rd_val = 8'd0;
  endtask

  task automatic test_reset();
    wait_res_edge("reset");
    n_cmp++;
    if ({bus_o, cs_o} !== {1'b0, 1'b1, 5'd0, 8'd0, 1'b0, 2'b00})
      begin n_fail++; $display("FAIL reset_bus got=%h exp=%h", {bus_o, cs_o}, {1'b0, 1'b1, 5'd0, 8'd0, 1'b0, 2'b00}); end
    n_cmp++;
    if ({cmd_ready, rd_valid, rd_data, busy} !== 11'd0)
      begin n_fail++; $display("FAIL reset_ctl got=%b%b%h%b exp=0", cmd_ready, rd_valid, rd_data, busy); end
    repeat (30) @(posedge clk);
  endtask

  task automatic test_write();
    clear_obs();
    drv_q.push_back(mk(OP_WRITE, 1'b0, 5'h18, 8'h0F));
    wait_done("write");
    n_cmp++;
    if (obs_wr !== 24) begin n_fail++; $display("FAIL write_len got=%0d exp=24", obs_wr); end
    n_cmp++;
    if (obs_wr_lo !== 12) begin n_fail++; $display("FAIL write_phi2_low got=%0d exp=12", obs_wr_lo); end
    for (int i = 0; i < 4; i++) begin
      drv_q.push_back(mk(OP_WRITE, 1'($urandom), 5'($urandom), 8'($urandom)));
      wait_done("write_rand");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drv_q.push_back(mk(OP_WRITE, 1'($urandom), 5'($urandom), 8'($urandom)));
      drv_q.push_back(mk(OP_WRITE, 1'($urandom), 5'($urandom), 8'($urandom)));
      wait_done("b2b");
    end
  endtask

  task automatic test_wait();
    clear_obs();
    drv_q.push_back(mk(OP_WAIT, 1'b0, 5'd0, 8'd3));
    drv_q.push_back(mk(OP_WRITE, 1'b0, 5'h18, 8'h0F));
    wait_done("wait3");
    n_cmp++;
    if (obs_idle_busy !== 72) begin n_fail++; $display("FAIL wait3_len got=%0d exp=72", obs_idle_busy); end
    clear_obs();
    drv_q.push_back(mk(OP_WAIT, 1'b0, 5'd0, 8'd0));
    wait_done("wait0");
    n_cmp++;
    if (obs_idle_busy !== 24) begin n_fail++; $display("FAIL wait0_len got=%0d exp=24", obs_idle_busy); end
    clear_obs();
    drv_q.push_back(mk(OP_WAIT, 1'b0, 5'd1, 8'd0));
    wait_done("wait256");
    n_cmp++;
    if (obs_idle_busy !== 256 * DIV) begin n_fail++; $display("FAIL wait256_len got=%0d exp=%0d", obs_idle_busy, 256 * DIV); end
  endtask

  task automatic test_read();
    clear_obs();
    din_fixed = 8'hA5;
    repeat (DIV) @(posedge clk);
    drv_q.push_back(mk(OP_READ, 1'b1, 5'h1B, 8'h00));
    wait_done("read");
    din_fixed = -1;
`ifdef SID_BUS_MASTER_READ_EN
    n_cmp++;
    if (obs_rdv !== 1 || obs_rd_val !== 8'hA5)
      begin n_fail++; $display("FAIL read_result got=%0d/%h exp=1/a5", obs_rdv, obs_rd_val); end
    n_cmp++;
    if (obs_rdcs !== 24) begin n_fail++; $display("FAIL read_cs_len got=%0d exp=24", obs_rdcs); end
`else
    n_cmp++;
    if (obs_rdv !== 0 || obs_rdcs !== 0)
      begin n_fail++; $display("FAIL read_disabled got=%0d/%0d exp=0/0", obs_rdv, obs_rdcs); end
`endif
  endtask

  task automatic test_reset_cmd();
    clear_obs();
    drv_q.push_back(mk(OP_RESET, 1'b0, 5'd0, 8'd0));
    wait_done("reset_cmd");
    n_cmp++;
    if (obs_res_hi !== RESN * DIV) begin n_fail++; $display("FAIL reset_cmd_len got=%0d exp=%0d", obs_res_hi, RESN * DIV); end
  endtask

  task automatic test_mid_reset();
    int k;
    drv_q.push_back(mk(OP_WAIT, 1'b0, 5'd0, 8'd5));
    repeat (40) @(posedge clk);
    rst_req = 1;
    wait_res_edge("mid_wait");
    n_cmp++;
    if ({busy, bus_o.phi2, cs_o, bus_o.res, rd_valid} !== 6'd0)
      begin n_fail++; $display("FAIL mid_wait_reset got=%b exp=0", {busy, bus_o.phi2, cs_o, bus_o.res, rd_valid}); end
    drv_q.push_back(mk(OP_WRITE, 1'b1, 5'($urandom), 8'($urandom)));
    wait_done("after_reset_write");
    clear_obs();
    drv_q.push_back(mk(OP_READ, 1'b1, 5'h1B, 8'h00));
    k = 0;
    while (!(cs_o === 2'b10 && bus_o.phi2 === 1'b1) && k < 200) begin @(posedge clk); k++; end
`ifdef SID_BUS_MASTER_READ_EN
    n_cmp++;
    if (k >= 200) begin n_fail++; $display("FAIL timeout mid_read got=%0d exp<200", k); end
`endif
    rst_req = 1;
    wait_res_edge("mid_read");
    wait_done("mid_read_settle");
    n_cmp++;
    if (obs_rdv !== 0) begin n_fail++; $display("FAIL mid_read_rdv got=%0d exp=0", obs_rdv); end
  endtask

  task automatic test_random();
    bus_cmd_t c;
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        c = mk(bus_op_t'(2'($urandom_range(0, 3))), 1'($urandom), 5'($urandom), 8'($urandom));
        if (c.op == OP_WAIT) begin c.addr = 5'd0; c.data = 8'($urandom_range(0, 4)); end
        if (c.op == OP_RESET && $urandom_range(0, 3) != 0) c.op = OP_WRITE;
        drv_q.push_back(c);
      end
      if ($urandom_range(0, 1) == 1) wait_done("random");
      else repeat ($urandom_range(1, 60)) @(posedge clk);
    end
    wait_done("random_end");
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_write();
    test_back_to_back();
    test_wait();
    test_read();
    test_reset_cmd();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
